// File: rtl/apb_cmd_master.sv
// apb_cmd_master: APB4 requester that turns a valid/ready command channel
// into APB SETUP/ACCESS transfers and returns read data and error status on
// a valid/ready response channel. One transfer is outstanding at a time.
//
// Optional build macro: APB_CMD_MASTER_TIMEOUT_EN
//   When defined, an ACCESS-phase watchdog aborts a transfer after
//   TIMEOUT_CYCLES wait cycles and reports it as an error response.
//   When undefined, ACCESS waits for PREADY indefinitely.
module apb_cmd_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  // command channel
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  // response channel
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  // APB requester port
  output logic [ADDR_W-1:0]   PADDR,
  output logic                PSELx,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [DATA_W-1:0]   PWDATA,
  output logic [DATA_W/8-1:0] PSTRB,
  input  logic                PREADY,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PSLVERR
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t state_reg;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  // Wide enough to hold the limit itself.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Number of PREADY=0 cycles seen in the current ACCESS phase.
  logic [CNT_W-1:0] timeout_cnt_reg;
`else
  // The watchdog depth only matters when the watchdog is built in.
  localparam int timeout_cycles_unused = TIMEOUT_CYCLES;
`endif

  // Transfer sequencer: every output is a register written from here, so the
  // APB and handshake signals are glitch-free and change only on PCLK rise.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_reg <= ST_IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PADDR     <= '0;
      PSELx     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSTRB     <= '0;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
      timeout_cnt_reg <= '0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            // The APB output registers double as the command latch. Reads
            // never expose stale write data or strobes on the bus.
            cmd_ready <= 1'b0;
            PSELx     <= 1'b1;
            PENABLE   <= 1'b0;
            PWRITE    <= cmd_write;
            PADDR     <= cmd_addr;
            PWDATA    <= cmd_write ? cmd_wdata : '0;
            PSTRB     <= cmd_write ? cmd_strb : '0;
            state_reg <= ST_SETUP;
          end else begin
            // Ready is registered: it rises one cycle after IDLE is entered.
            cmd_ready <= 1'b1;
          end
        end

        ST_SETUP: begin
          PENABLE   <= 1'b1;
          state_reg <= ST_ACCESS;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
          timeout_cnt_reg <= '0;
`endif
        end

        ST_ACCESS: begin
          // PREADY has priority over the watchdog, so a slave answering on
          // the final allowed cycle still completes normally. PSLVERR only
          // has meaning alongside PREADY.
          if (PREADY) begin
            PSELx     <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            rsp_err   <= PSLVERR;
            state_reg <= ST_RESP;
          end
`ifdef APB_CMD_MASTER_TIMEOUT_EN
          else if (timeout_cnt_reg == CNT_LAST) begin
            // This wait cycle brings the count to the limit: abandon the bus.
            PSELx     <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            state_reg <= ST_RESP;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
          end
`endif
        end

        ST_RESP: begin
          // Response data stays frozen until the consumer takes it.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- APB4 requester that drives the APB slave/register-file wrapper; it sits directly upstream of that wrapper.
- Converts a simple valid/ready command channel into APB SETUP/ACCESS transfers.
- Returns read data and error status on a valid/ready response channel.
- One transfer outstanding at a time; this is the synthesizable replacement for the bench-side driver.

Parameters:
ADDR_W, 32, PADDR and cmd_addr width
DATA_W, 32, PWDATA/PRDATA width; must be a multiple of 8
TIMEOUT_CYCLES, 16, maximum ACCESS-phase wait cycles before abort (used only with the optional feature)

Ports:
PCLK  in  1  clock; all logic rising-edge
PRESETn  in  1  synchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
cmd_strb  in  DATA_W/8  byte strobes (write only)
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when valid&ready
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_err  out  1  PSLVERR captured, or timeout
PADDR  out  ADDR_W  APB address
PSELx  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  DATA_W  APB write data
PSTRB  out  DATA_W/8  APB strobes
PREADY  in  1  slave ready
PRDATA  in  DATA_W  slave read data
PSLVERR  in  1  slave error

Behaviour:
- Reset: sampled on PCLK rise while PRESETn=0 (synchronous, active-low). Synchronous with PCLK; no asynchronous path.
- Reset values: state=IDLE; PSELx=0, PENABLE=0, PWRITE=0; PADDR, PWDATA, PSTRB all zero; cmd_ready=0; rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Reset mid-transfer: drops PSELx and PENABLE on the next edge and discards the in-flight command; no response is produced.
- FSM state IDLE:
  - cmd_ready=1 (registered, asserted the cycle after entering IDLE).
  - On cmd_valid&cmd_ready: latch addr, write, wdata and strb; go to SETUP.
- FSM state SETUP (exactly 1 cycle):
  - PSELx=1, PENABLE=0; PADDR, PWRITE, PWDATA and PSTRB driven from the latched command.
  - Reads drive PSTRB=0 and PWDATA=0.
  - Next state ACCESS.
- FSM state ACCESS:
  - PSELx=1, PENABLE=1; all APB outputs held stable.
  - On PREADY=1: capture PRDATA (reads only; writes capture 0) and PSLVERR; deassert PSELx/PENABLE on the next edge; go to RESP.
  - PSLVERR is ignored unless PREADY=1.
- FSM state RESP:
  - rsp_valid=1; rsp_rdata and rsp_err held stable.
  - On rsp_ready: rsp_valid=0, go to IDLE.
  - rsp_ready asserted before rsp_valid has no effect.
- Latency with a zero-wait slave:
  - Accept edge N.
  - SETUP during cycle N+1.
  - ACCESS during cycle N+2.
  - rsp_valid during cycle N+3.
  - Next command accepted no earlier than N+5.
- Wait states: each PREADY=0 cycle in ACCESS adds one cycle of latency. With the timeout disabled there is no upper bound.
- cmd_ready=0 in every state except IDLE; commands presented at other times are held off, never dropped.
- Boundary handling:
  - cmd_addr and PADDR are passed through unmodified; no alignment check.
  - cmd_strb=0 on a write is legal and is passed through.

Optional Feature:
Macro: APB_CMD_MASTER_TIMEOUT_EN
- Defined:
  - A counter clears on SETUP→ACCESS and increments each ACCESS cycle with PREADY=0.
  - On reaching TIMEOUT_CYCLES: abort — PSELx=0, PENABLE=0 next edge, go to RESP with rsp_err=1 and rsp_rdata=0.
  - PREADY=1 on the same cycle the counter reaches the limit wins; the transfer completes normally.
- Undefined: no counter logic; ACCESS waits indefinitely for PREADY.

Test Plan:
- Reset: hold PRESETn=0 for 3 cycles with cmd_valid=1 → all outputs 0, no PSELx; cmd_ready rises 1 cycle after PRESETn=1.
- Zero-wait write: write addr=0x0000_0004, wdata=0xDEAD_BEEF, strb=0xF → SETUP then ACCESS with PSTRB=0xF; rsp_valid at accept+3 with rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: read addr=0x8 while slave returns PRDATA=0x1234_5678 after 3 PREADY=0 cycles → PENABLE high 4 cycles, PSTRB=0; rsp_rdata=0x1234_5678.
- Slave error with back-pressure: PSLVERR=1 with PREADY=1, rsp_ready held 0 for 5 cycles → rsp_err=1 held stable; cmd_ready stays 0 until the response is consumed.
- Reset mid-transfer: assert PRESETn=0 during ACCESS → PSELx=0 next edge; no rsp_valid after reset release.
- Timeout (with APB_CMD_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16): PREADY tied 0 → abort after 16 ACCESS cycles; rsp_err=1, rsp_rdata=0. Repeat with PREADY=1 on the 16th cycle → normal completion, rsp_err=0.
